// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and default widths for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fairness counter: counts DMEM grants taken while a fetch waits and
// forces the next arbitration to IF once the limit is reached.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dmem_grant,
  input  logic i_if_grant,
  input  logic i_imem_req,
  output logic o_force_if
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_if_grant) begin
      cnt_d = '0;
    end else if (i_dmem_grant && i_imem_req && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_force_if = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between IF and MEM.
// Optional anti-starvation for fetches is enabled with MEM_ARB_FAIR_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_imem_req,
  input  logic [ADDR_W-1:0]   i_imem_addr,
  input  logic                i_if_flush,
  output logic                o_imem_done,
  output logic [DATA_W-1:0]   o_imem_rdata,
  output logic                o_stall_if,
  input  logic                i_dmem_req,
  input  logic                i_dmem_we,
  input  logic [ADDR_W-1:0]   i_dmem_addr,
  input  logic [DATA_W-1:0]   i_dmem_wdata,
  input  logic [DATA_W/8-1:0] i_dmem_wmask,
  output logic                o_dmem_done,
  output logic [DATA_W-1:0]   o_dmem_rdata,
  output logic                o_stall_mem,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic [DATA_W/8-1:0] o_bus_wmask,
  input  logic                i_bus_gnt,
  input  logic                i_bus_rvalid,
  input  logic [DATA_W-1:0]   i_bus_rdata
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                squash_q, squash_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W/8-1:0] bus_wmask_q, bus_wmask_d;

  logic starve_force;
  logic if_wins;
  logic if_grant;
  logic dmem_grant;
  logic resp_fire;

  // DMEM is older and wins ties unless the fairness counter forces IF.
  assign if_wins    = i_imem_req && !i_if_flush && (!i_dmem_req || starve_force);
  assign if_grant   = (state_q == ST_IDLE) && if_wins;
  assign dmem_grant = (state_q == ST_IDLE) && i_dmem_req && !if_wins;

`ifdef MEM_ARB_FAIR_EN
  mem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_dmem_grant(dmem_grant),
    .i_if_grant  (if_grant),
    .i_imem_req  (i_imem_req),
    .o_force_if  (starve_force)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign starve_force        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    squash_d    = squash_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    o_bus_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_grant) begin
          owner_d     = OWN_DMEM;
          bus_we_d    = i_dmem_we;
          bus_addr_d  = i_dmem_addr;
          bus_wdata_d = i_dmem_wdata;
          bus_wmask_d = i_dmem_wmask;
          state_d     = ST_REQ;
        end else if (if_grant) begin
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_addr_d  = i_imem_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // A flushed fetch that has not been accepted can simply be withdrawn.
        if ((owner_q == OWN_IF) && i_if_flush) begin
          state_d = ST_IDLE;
        end else begin
          o_bus_req = 1'b1;
          if (i_bus_gnt) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_bus_rvalid) begin
          state_d  = ST_IDLE;
          squash_d = 1'b0;
        end else if ((owner_q == OWN_IF) && i_if_flush) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      squash_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      squash_q    <= squash_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
    end
  end

  assign resp_fire    = (state_q == ST_WAIT) && i_bus_rvalid && !squash_q;
  assign o_imem_done  = resp_fire && (owner_q == OWN_IF);
  assign o_dmem_done  = resp_fire && (owner_q == OWN_DMEM);
  assign o_imem_rdata = o_imem_done ? i_bus_rdata : '0;
  assign o_dmem_rdata = o_dmem_done ? i_bus_rdata : '0;
  assign o_stall_if   = i_imem_req && !o_imem_done;
  assign o_stall_mem  = i_dmem_req && !o_dmem_done;

  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_bus_wmask = bus_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, random
// transactions against a timeline/memory model, and flush/reset/fairness sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq, ifFlush, dmemReq, dmemWe, busGnt, busRvalid;
  logic [31:0] imemAddr, dmemAddr, dmemWdata, busRdata;
  logic [3:0]  dmemWmask;
  logic        imemDone, stallIf, dmemDone, stallMem, busReq, busWe;
  logic [31:0] imemRdata, dmemRdata, busAddr, busWdata;
  logic [3:0]  busWmask;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] busMem[logic [31:0]];
  logic [31:0] modelMem[logic [31:0]];

  typedef struct {
    bit          doIf;
    bit          doD;
    bit          dWe;
    logic [31:0] ifAddr;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dWmask;
    int          g1, r1, g2, r2;
    int          expIfDone;
    int          expDDone;
    logic [31:0] expIfRd;
    logic [31:0] expDRd;
  } vec_t;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_imem_req  (imemReq),
    .i_imem_addr (imemAddr),
    .i_if_flush  (ifFlush),
    .o_imem_done (imemDone),
    .o_imem_rdata(imemRdata),
    .o_stall_if  (stallIf),
    .i_dmem_req  (dmemReq),
    .i_dmem_we   (dmemWe),
    .i_dmem_addr (dmemAddr),
    .i_dmem_wdata(dmemWdata),
    .i_dmem_wmask(dmemWmask),
    .o_dmem_done (dmemDone),
    .o_dmem_rdata(dmemRdata),
    .o_stall_mem (stallMem),
    .o_bus_req   (busReq),
    .o_bus_we    (busWe),
    .o_bus_addr  (busAddr),
    .o_bus_wdata (busWdata),
    .o_bus_wmask (busWmask),
    .i_bus_gnt   (busGnt),
    .i_bus_rvalid(busRvalid),
    .i_bus_rdata (busRdata)
  );

  function automatic logic [31:0] initVal(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] a);
    return modelMem.exists(a) ? modelMem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] busRead(logic [31:0] a);
    return busMem.exists(a) ? busMem[a] : initVal(a);
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    imemReq = 0; imemAddr = 0; ifFlush = 0;
    dmemReq = 0; dmemWe = 0; dmemAddr = 0; dmemWdata = 0; dmemWmask = 0;
    busGnt = 0; busRvalid = 0; busRdata = 0;
  endtask

  // Runs one request set (fetch and/or data access raised together) with a
  // reactive bus responder; expectations come from the access timeline.
  task automatic applyStimulus(int vi, vec_t v);
    int rs[2], re[2], gArr[2], rArr[2];
    bit isD[2];
    int nTx, lastCyc, done1, rspIdx, reqCnt, waitCnt;
    bit inWait;
    logic [31:0] wA, wD;
    logic wWe;
    logic [3:0] wM;
    bit expReq, expIfD, expDD;
    int w;
    nTx = (v.doIf && v.doD) ? 2 : 1;
    isD[0] = v.doD; isD[1] = 1'b0;
    gArr[0] = v.g1; rArr[0] = v.r1; gArr[1] = v.g2; rArr[1] = v.r2;
    done1 = 3 + v.g1 + v.r1;
    rs[0] = 2; re[0] = 2 + v.g1;
    rs[1] = done1 + 2; re[1] = done1 + 2 + v.g2;
    lastCyc = (nTx == 2) ? done1 + 3 + v.g2 + v.r2 : done1;
    rspIdx = 0; reqCnt = 0; waitCnt = 0; inWait = 0;
    wA = 0; wD = 0; wWe = 0; wM = 0;
    for (int k = 1; k <= lastCyc + 1; k++) begin
      @(negedge clk);
      imemReq   = v.doIf && (k <= v.expIfDone);
      imemAddr  = v.ifAddr;
      dmemReq   = v.doD && (k <= v.expDDone);
      dmemWe    = v.dWe;
      dmemAddr  = v.dAddr;
      dmemWdata = v.dWdata;
      dmemWmask = v.dWmask;
      busGnt = 0; busRvalid = 0; busRdata = 0;
      #1;
      if (inWait) begin
        if (waitCnt == rArr[rspIdx & 1]) begin
          busRvalid = 1;
          busRdata  = wWe ? 32'h0 : busRead(wA);
          if (wWe) busMem[wA] = merge(busRead(wA), wD, wM);
          inWait = 0; rspIdx++; reqCnt = 0;
        end else waitCnt++;
      end else if (busReq) begin
        if (reqCnt == gArr[rspIdx & 1]) begin
          busGnt = 1; inWait = 1; waitCnt = 0;
          wA = busAddr; wD = busWdata; wWe = busWe; wM = busWmask;
        end else reqCnt++;
      end
      #1;
      w = -1;
      for (int t = 0; t < nTx; t++) if (k >= rs[t] && k <= re[t]) w = t;
      expReq = (w >= 0);
      expIfD = v.doIf && (k == v.expIfDone);
      expDD  = v.doD && (k == v.expDDone);
      checkOutput($sformatf("v%0d k%0d bus_req", vi, k), 32'(busReq), 32'(expReq));
      if (expReq) begin
        checkOutput($sformatf("v%0d k%0d bus_addr", vi, k), busAddr, isD[w] ? v.dAddr : v.ifAddr);
        checkOutput($sformatf("v%0d k%0d bus_we", vi, k), 32'(busWe), 32'(isD[w] && v.dWe));
        if (isD[w]) begin
          checkOutput($sformatf("v%0d k%0d bus_wdata", vi, k), busWdata, v.dWdata);
          checkOutput($sformatf("v%0d k%0d bus_wmask", vi, k), 32'(busWmask), 32'(v.dWmask));
        end
      end
      checkOutput($sformatf("v%0d k%0d imem_done", vi, k), 32'(imemDone), 32'(expIfD));
      checkOutput($sformatf("v%0d k%0d dmem_done", vi, k), 32'(dmemDone), 32'(expDD));
      checkOutput($sformatf("v%0d k%0d imem_rdata", vi, k), imemRdata, expIfD ? v.expIfRd : 32'h0);
      checkOutput($sformatf("v%0d k%0d dmem_rdata", vi, k), dmemRdata, expDD ? v.expDRd : 32'h0);
      checkOutput($sformatf("v%0d k%0d stall_if", vi, k), 32'(stallIf), 32'(imemReq && !expIfD));
      checkOutput($sformatf("v%0d k%0d stall_mem", vi, k), 32'(stallMem), 32'(dmemReq && !expDD));
    end
  endtask

  function automatic vec_t mk(bit doIf, bit doD, bit dWe, logic [31:0] ifA, logic [31:0] dA,
                              logic [31:0] wd, logic [3:0] wm, int g1, int r1, int g2, int r2);
    vec_t v;
    v.doIf = doIf; v.doD = doD; v.dWe = dWe; v.ifAddr = ifA; v.dAddr = dA;
    v.dWdata = wd; v.dWmask = wm; v.g1 = g1; v.r1 = r1; v.g2 = g2; v.r2 = r2;
    v.expIfDone = 0; v.expDDone = 0; v.expIfRd = 0; v.expDRd = 0;
    return v;
  endfunction

  // Reference model: completion times and data derived from access order
  // (data first when both request) and byte-masked memory contents.
  function automatic vec_t predict(vec_t v);
    vec_t p;
    int t1;
    p = v;
    t1 = 3 + v.g1 + v.r1;
    if (v.doD) begin
      p.expDDone = t1;
      if (v.dWe) begin
        modelMem[v.dAddr] = merge(modelRead(v.dAddr), v.dWdata, v.dWmask);
        p.expDRd = 0;
      end else p.expDRd = modelRead(v.dAddr);
      if (v.doIf) p.expIfDone = t1 + 3 + v.g2 + v.r2;
    end else if (v.doIf) p.expIfDone = t1;
    if (v.doIf) p.expIfRd = modelRead(v.ifAddr);
    return p;
  endfunction

  vec_t table_v[6];
  vec_t rv;

`ifdef MEM_ARB_FAIR_EN
  localparam int EXP_D_BEFORE_IF = 4;
`else
  localparam int EXP_D_BEFORE_IF = -1;
`endif

  initial begin
    int dGrants, ifAfter;
    bit pendRsp;
    clearInputs();
    rst = 1;
    busMem[32'h100]   = 32'h0050_0093;
    modelMem[32'h100] = 32'h0050_0093;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset bus_req", 32'(busReq), 32'h0);
    checkOutput("reset bus_addr", busAddr, 32'h0);
    checkOutput("reset bus_we", 32'(busWe), 32'h0);
    checkOutput("reset bus_wdata", busWdata, 32'h0);
    checkOutput("reset bus_wmask", 32'(busWmask), 32'h0);
    checkOutput("reset done/stall", {28'h0, imemDone, dmemDone, stallIf, stallMem}, 32'h0);
    @(negedge clk);
    rst = 0;

    // Directed vectors; expected completion cycles and data are hand-derived.
    table_v[0] = mk(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    table_v[0].expIfDone = 3; table_v[0].expIfRd = 32'h0050_0093;
    table_v[1] = mk(1, 1, 0, 32'h104, 32'h2000, 0, 4'h0, 0, 0, 0, 0);
    table_v[1].expDDone = 3; table_v[1].expIfDone = 6;
    table_v[1].expDRd = 32'h5A5A_2000; table_v[1].expIfRd = 32'h5A5A_0104;
    table_v[2] = mk(0, 1, 1, 0, 32'h2004, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 0);
    table_v[2].expDDone = 6; table_v[2].expDRd = 0;
    table_v[3] = mk(0, 1, 0, 0, 32'h2004, 0, 4'h0, 1, 2, 0, 0);
    table_v[3].expDDone = 6; table_v[3].expDRd = 32'hDEAD_BEEF;
    table_v[4] = mk(1, 1, 1, 32'h2004, 32'h2004, 32'h1122_3344, 4'h5, 0, 1, 2, 0);
    table_v[4].expDDone = 4; table_v[4].expIfDone = 9;
    table_v[4].expDRd = 0; table_v[4].expIfRd = 32'hDE22_BE44;
    table_v[5] = mk(1, 0, 0, 32'h108, 0, 0, 0, 2, 3, 0, 0);
    table_v[5].expIfDone = 8; table_v[5].expIfRd = 32'h5A5A_0108;
    for (int i = 0; i < 6; i++) begin
      if (table_v[i].doD && table_v[i].dWe)
        modelMem[table_v[i].dAddr] = merge(modelRead(table_v[i].dAddr),
                                           table_v[i].dWdata, table_v[i].dWmask);
      applyStimulus(i, table_v[i]);
    end

    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      rv = mk(sel != 1, sel != 0, 1'($urandom_range(0, 1)),
              32'h2000 + 32'($urandom_range(0, 7)) * 4, 32'h2000 + 32'($urandom_range(0, 7)) * 4,
              $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rv = predict(rv);
      applyStimulus(100 + i, rv);
    end

    // Flush while the fetch is waiting for its response: response is consumed silently.
    clearInputs();
    @(negedge clk); imemReq = 1; imemAddr = 32'h100; #1;
    @(negedge clk); busGnt = 1; #1;
    checkOutput("flushW req", 32'(busReq), 32'h1);
    @(negedge clk); busGnt = 0; ifFlush = 1; #1;
    checkOutput("flushW wait done", 32'(imemDone), 32'h0);
    @(negedge clk); ifFlush = 0; imemAddr = 32'h200; #1;
    checkOutput("flushW wait2 req", 32'(busReq), 32'h0);
    @(negedge clk); busRvalid = 1; busRdata = 32'hBAD0_BAD0; #1;
    checkOutput("flushW squashed done", 32'(imemDone), 32'h0);
    checkOutput("flushW squashed rdata", imemRdata, 32'h0);
    checkOutput("flushW stall", 32'(stallIf), 32'h1);
    @(negedge clk); busRvalid = 0; busRdata = 0; #1;
    checkOutput("flushW idle req", 32'(busReq), 32'h0);
    @(negedge clk); busGnt = 1; #1;
    checkOutput("flushW refetch req", 32'(busReq), 32'h1);
    checkOutput("flushW refetch addr", busAddr, 32'h200);
    @(negedge clk); busGnt = 0; busRvalid = 1; busRdata = 32'h0000_0013; #1;
    checkOutput("flushW refetch done", 32'(imemDone), 32'h1);
    checkOutput("flushW refetch rdata", imemRdata, 32'h0000_0013);
    @(negedge clk); clearInputs(); #1;

    // Flush while the fetch is still requesting: request is withdrawn, gnt ignored.
    @(negedge clk); imemReq = 1; imemAddr = 32'h300; #1;
    @(negedge clk); #1;
    checkOutput("flushR req", 32'(busReq), 32'h1);
    @(negedge clk); ifFlush = 1; busGnt = 1; #1;
    checkOutput("flushR dropped req", 32'(busReq), 32'h0);
    @(negedge clk); ifFlush = 0; busGnt = 0; imemAddr = 32'h304; #1;
    checkOutput("flushR idle req", 32'(busReq), 32'h0);
    @(negedge clk); busGnt = 1; #1;
    checkOutput("flushR new addr", busAddr, 32'h304);
    @(negedge clk); busGnt = 0; busRvalid = 1; busRdata = 32'hCAFE_0304; #1;
    checkOutput("flushR done", 32'(imemDone), 32'h1);
    @(negedge clk); clearInputs(); #1;

    // Reset in WAIT, late response afterwards must be ignored.
    @(negedge clk); imemReq = 1; imemAddr = 32'h500; #1;
    @(negedge clk); busGnt = 1; #1;
    @(negedge clk); busGnt = 0; rst = 1; #1;
    checkOutput("rstW bus_req", 32'(busReq), 32'h0);
    checkOutput("rstW bus_addr", busAddr, 32'h0);
    @(negedge clk); rst = 0; busRvalid = 1; busRdata = 32'hBAD1_BAD1; #1;
    checkOutput("rstW late done", 32'(imemDone), 32'h0);
    checkOutput("rstW late req", 32'(busReq), 32'h0);
    checkOutput("rstW stall", 32'(stallIf), 32'h1);
    @(negedge clk); busRvalid = 0; busRdata = 0; busGnt = 1; #1;
    checkOutput("rstW reissue req", 32'(busReq), 32'h1);
    checkOutput("rstW reissue addr", busAddr, 32'h500);
    @(negedge clk); busGnt = 0; busRvalid = 1; busRdata = 32'h1234_5678; #1;
    checkOutput("rstW done", 32'(imemDone), 32'h1);
    checkOutput("rstW rdata", imemRdata, 32'h1234_5678);
    @(negedge clk); clearInputs(); #1;
    checkOutput("rstW idle stall", 32'(stallIf), 32'h0);

    // Both stages request continuously; count DMEM grants before IF gets the bus.
    rst = 1;
    @(negedge clk); rst = 0;
    dGrants = 0; ifAfter = -1; pendRsp = 0;
    for (int k = 0; k < 80 && ifAfter < 0 && dGrants < 10; k++) begin
      @(negedge clk);
      imemReq = 1; imemAddr = 32'h400; dmemReq = 1; dmemWe = 0; dmemAddr = 32'h3000;
      busGnt = 0; busRvalid = pendRsp; busRdata = 32'h0; pendRsp = 0;
      #1;
      if (busReq) begin
        busGnt = 1; pendRsp = 1;
        if (busAddr == 32'h3000) dGrants++;
        else if (busAddr == 32'h400) ifAfter = dGrants;
      end
    end
    checkOutput("fair dmem grants before fetch", 32'(ifAfter), 32'(EXP_D_BEFORE_IF));
    @(negedge clk); clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store), one outstanding transaction at a time. It raises per-stage stalls until each access completes. Those stalls are ORed with the load-use stalls in the pipeline control. It sits between the pipeline and the memory/bus wrapper.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
STARVE_LIMIT, 4, consecutive DMEM grants allowed while IF waits (used only with the optional feature)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_imem_req  in  1  IF requests fetch; held stable until o_imem_done
i_imem_addr  in  ADDR_W  fetch address
i_if_flush  in  1  squash the in-flight/pending fetch (taken branch/jump)
o_imem_done  out  1  fetch complete this cycle
o_imem_rdata  out  DATA_W  fetch data, valid with o_imem_done
o_stall_if  out  1  i_imem_req && !o_imem_done
i_dmem_req  in  1  MEM requests access; held stable until o_dmem_done
i_dmem_we  in  1  1 = store
i_dmem_addr  in  ADDR_W  data address
i_dmem_wdata  in  DATA_W  store data
i_dmem_wmask  in  DATA_W/8  byte enables
o_dmem_done  out  1  data access complete this cycle
o_dmem_rdata  out  DATA_W  load data, valid with o_dmem_done
o_stall_mem  out  1  i_dmem_req && !o_dmem_done
o_bus_req  out  1  request to memory; high in REQ state
o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
i_bus_gnt  in  1  memory accepted request this cycle
i_bus_rvalid  in  1  response/ack (reads and writes)
i_bus_rdata  in  DATA_W  read data

Behaviour:
- Clock and reset: single clock i_clk; i_rst asynchronous, active-high.
- Reset values: state IDLE, owner IF, squash 0, starve counter 0, all o_bus_* fields 0. Done and stall outputs follow combinationally and are 0 while no requests are present.
- FSM states:
  - IDLE: arbitrate. If any request is present, latch owner and request fields into registers, then go to REQ. IF-only with i_if_flush high: no grant.
  - REQ: o_bus_req=1, fields stable. On i_bus_gnt go to WAIT.
  - WAIT: on i_bus_rvalid go to IDLE.
- Priority: DMEM beats IF on simultaneous requests, because the MEM instruction is older.
- Done: o_x_done = (state==WAIT) && i_bus_rvalid && owner==x && !squash. o_x_rdata passes i_bus_rdata through when done, 0 otherwise.
- Latency: minimum 3 cycles per access (IDLE sample, REQ with same-cycle gnt, WAIT with rvalid). The pipeline advances on the done edge, and the arbiter re-samples the new request in IDLE the next cycle, so there is no double issue.
- Stores complete on i_bus_rvalid (write ack) exactly like loads.
- Flush:
  - In REQ with owner IF: i_if_flush drops o_bus_req and returns to IDLE (no gnt was taken).
  - In WAIT with owner IF: sets squash. rvalid is still consumed, o_imem_done is suppressed, and squash clears on return to IDLE.
  - Flush has no effect on a DMEM transaction.
- i_bus_rvalid outside WAIT is ignored, including a late response after reset mid-transaction.
- o_stall_if stays high while a DMEM access is owned, even if the fetch is pending.

Optional Feature:
MEM_ARB_FAIR_EN:
- Defined: an up-counter (saturating at STARVE_LIMIT) increments on each DMEM grant made while i_imem_req is high. It clears on any IF grant. In IDLE with both requesting and counter==STARVE_LIMIT, IF wins.
- Undefined: strict DMEM priority; the counter is not instantiated.

Decomposition:
- Shared package: state encoding (IDLE/REQ/WAIT, 2 bits), owner encoding (OWN_IF=0, OWN_DMEM=1), default widths.
- One natural sub-module, mem_arb_starve_ctr. It holds the fairness counter and its compare, and is instantiated only under MEM_ARB_FAIR_EN.

Test Plan:
- Fetch 0x100 alone, gnt in REQ cycle, rvalid next cycle with rdata 0x00500093 → o_bus_req high 1 cycle, o_imem_done + rdata at cycle 3, o_stall_if high cycles 1–2.
- Simultaneous fetch 0x104 and load 0x2000 → load served first (o_bus_addr=0x2000, we=0), fetch issued in the IDLE after o_dmem_done.
- Store 0xDEADBEEF, mask 0xF, to 0x2004, with gnt delayed 3 cycles → o_bus_* stable throughout REQ, done on ack, o_dmem_rdata=0.
- i_if_flush during WAIT of a fetch, rvalid 2 cycles later → no o_imem_done; the next fetch (new PC 0x200) is issued after IDLE.
- Assert i_rst in WAIT, then deliver rvalid after reset → state IDLE, no done pulse, o_bus_req 0.
- With MEM_ARB_FAIR_EN, STARVE_LIMIT=4, dmem and imem both held continuously → IF is granted after exactly 4 consecutive DMEM grants. Without the macro, IF is never granted.
